if_id_queue: RTL and testbench

- Parametrised fetch/decode decoupling queue; successor to the single-entry IF/ID pipeline register.
- Sits between the fetch stage (with branch predictor) and the decode stage.
- Buffers up to DEPTH fetched instructions, each entry holding pc, predicted next_pc, instruction word and predicted-taken bit.
- Decouples the two stages with valid/ready handshakes and supports a single-cycle flush on branch mispredict or redirect.

---
 rtl/if_id_pkg.sv | 22 ++
 rtl/sync_fifo_core.sv | 70 +++++++
 rtl/if_id_queue.sv | 74 +++++++
 tb/tb_if_id_queue.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared definitions for the fetch/decode decoupling queue: entry layout,
// the empty-queue instruction and the occupancy counter width helper.
package if_id_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [ILEN-1:0] inst;
    logic            predicted_bit;
  } if_id_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Generic WIDTH x DEPTH synchronous FIFO with combinational head read.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo_core
  import if_id_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Flags come from the registered count only, so a full FIFO never
  // accepts a push even when a pop happens in the same cycle.
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; readers mask the head while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/if_id_queue.sv
// Fetch/decode decoupling queue: packs fetch entries into a FIFO core,
// masks the head while empty and discards everything on flush.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(if_id_pkg::NOP_INST)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          if_valid,
  output logic                          if_ready,
  input  logic [XLEN-1:0]               if_pc,
  input  logic [XLEN-1:0]               if_next_pc,
  input  logic [ILEN-1:0]               if_inst,
  input  logic                          if_predicted_bit,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [XLEN-1:0]               id_pc,
  output logic [XLEN-1:0]               id_next_pc,
  output logic [ILEN-1:0]               id_inst,
  output logic                          id_predicted_bit,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int EW = 2 * XLEN + ILEN + 1;

  logic [EW-1:0]   wr_entry, head_entry;
  logic            full, empty;
  logic [XLEN-1:0] head_pc, head_next_pc;
  logic [ILEN-1:0] head_inst;
  logic            head_predicted_bit;

  assign wr_entry = {if_pc, if_next_pc, if_inst, if_predicted_bit};

  sync_fifo_core #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (if_valid),
    .pop     (id_ready),
    .wr_data (wr_entry),
    .rd_data (head_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign {head_pc, head_next_pc, head_inst, head_predicted_bit} = head_entry;

  assign if_ready = ~full;
  assign id_valid = ~empty;

  // An empty queue looks like a bubble to decode.
  always_comb begin
    id_pc            = '0;
    id_next_pc       = '0;
    id_inst          = NOP_INST;
    id_predicted_bit = 1'b0;
    if (!empty) begin
      id_pc            = head_pc;
      id_next_pc       = head_next_pc;
      id_inst          = head_inst;
      id_predicted_bit = head_predicted_bit;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: the driver pushes accepted entries into
// an expected queue, a negedge monitor compares and pops on every handshake.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, if_predicted_bit;
  logic        id_valid, id_ready, id_predicted_bit;
  logic [31:0] if_pc, if_next_pc, if_inst, id_pc, id_next_pc, id_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  if_id_entry_t exp_q[$];

  always #5 clk = ~clk;

  if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_next_pc       (if_next_pc),
    .if_inst          (if_inst),
    .if_predicted_bit (if_predicted_bit),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_pc            (id_pc),
    .id_next_pc       (id_next_pc),
    .id_inst          (id_inst),
    .id_predicted_bit (id_predicted_bit),
    .count            (count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compares flags every cycle and the head whenever DUT presents it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("if_ready", 32'(if_ready), 32'(exp_q.size() != DEPTH));
      chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        chk("empty_pc", id_pc, 32'h0);
        chk("empty_next_pc", id_next_pc, 32'h0);
        chk("empty_inst", id_inst, NOP_INST);
        chk("empty_pbit", 32'(id_predicted_bit), 32'h0);
      end else if (id_valid) begin
        chk("head_pc", id_pc, exp_q[0].pc);
        chk("head_next_pc", id_next_pc, exp_q[0].next_pc);
        chk("head_inst", id_inst, exp_q[0].inst);
        chk("head_pbit", 32'(id_predicted_bit), 32'(exp_q[0].predicted_bit));
      end
      if (id_valid && id_ready && !flush && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual_pc=%h required=none at %0t", id_pc, $time);
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drives one cycle; the entry is expected if the queue has room by the
  // model's own occupancy (room is judged before any same-cycle dequeue).
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] npc,
                      input logic [31:0] inst, input logic pb, input logic rdy,
                      input logic fl, input logic r);
    if_id_entry_t e;
    bit do_enq;
    if_valid = v; if_pc = pc; if_next_pc = npc; if_inst = inst;
    if_predicted_bit = pb; id_ready = rdy; flush = fl; rst = r;
    e.pc = pc; e.next_pc = npc; e.inst = inst; e.predicted_bit = pb;
    do_enq = v && !fl && !r && (exp_q.size() != DEPTH);
    @(posedge clk);
    if (r || fl) exp_q.delete();
    else if (do_enq) exp_q.push_back(e);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic rdy);
    step(1'b1, pc, pc + 32'd4, $urandom, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'hDEAD_0000, 32'hDEAD_0004, 32'hFFFF_FFFF, 1'b1, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_next_pc = '0; if_inst = '0; if_predicted_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1'b0);

    // Fill to DEPTH, a fifth offer is refused, then drain in order.
    for (int i = 0; i < 4; i++) offer(32'h100 + 32'(4 * i), 1'b0);
    offer(32'h110, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Continuous streaming through wrap-around.
    for (int i = 0; i < 10; i++) offer(32'h200 + 32'(4 * i), 1'b1);
    idle(1'b1);

    // Flush with a simultaneous offer and dequeue.
    for (int i = 0; i < 3; i++) offer(32'h380 + 32'(4 * i), 1'b0);
    step(1'b1, 32'h300, 32'h304, 32'h0000_0093, 1'b0, 1'b1, 1'b1, 1'b0);
    offer(32'h400, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stalled head stays stable while entries queue behind it.
    step(1'b1, 32'h500, 32'h540, 32'h0400_006F, 1'b1, 1'b0, 1'b0, 1'b0);
    offer(32'h504, 1'b0);
    offer(32'h508, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Full boundary: dequeue only, fetch re-offers next cycle.
    for (int i = 0; i < 4; i++) offer(32'h600 + 32'(4 * i), 1'b0);
    offer(32'h610, 1'b1);
    offer(32'h610, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 65, 32'h1000 + 32'(4 * i), $urandom, $urandom,
           1'($urandom), $urandom_range(0, 99) < 60,
           $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
